// File: rtl/tl45_decode.sv
// rtl/tl45_decode.sv - tl45 decode/register-fetch stage with forwarding and load-use stall.
// Build option TL45_WB_BYPASS_EN: same-cycle writeback bypass instead of a one-cycle stall.
module tl45_decode (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_pipe_stall,
   output logic        o_pipe_stall,
   input  logic        i_pipe_flush,
   output logic        o_pipe_flush,
   input  logic        i_valid,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc,
   input  logic [3:0]  i_of_reg,
   input  logic [31:0] i_of_val,
   input  logic [3:0]  i_mem_of_reg,
   input  logic [31:0] i_mem_of_val,
   input  logic [3:0]  i_wb_reg,
   input  logic [31:0] i_wb_val,
   output logic [3:0]  o_opcode,
   output logic [3:0]  o_dr,
   output logic        o_skp_mode,
   output logic [31:0] o_pc,
   output logic [31:0] o_sr1_val,
   output logic [31:0] o_sr2_val,
   output logic [31:0] o_target_address,
   output logic        o_halted
);

   logic [31:0] regs [16];

   logic [3:0]  op, rx, ry, rz;
   logic [31:0] imm, vx, vy, vz;
   logic [3:0]  d_op, d_dr;
   logic        d_skp, bubble_op;
   logic [31:0] d_sr1, d_sr2, d_tgt;
   logic        use_x, use_y, use_z;
   logic        load_use, wb_haz, hazard;

   assign op  = i_instr[31:28];
   assign rx  = i_instr[27:24];
   assign ry  = i_instr[23:20];
   assign rz  = i_instr[3:0];
   assign imm = {{12{i_instr[19]}}, i_instr[19:0]};

   function automatic logic [31:0] rd(input logic [3:0] r);
      if (r == 4'd0)
         rd = 32'd0;
      else if (i_of_reg == r)
         rd = i_of_val;
      else if (i_mem_of_reg == r)
         rd = i_mem_of_val;
`ifdef TL45_WB_BYPASS_EN
      else if (i_wb_reg == r)
         rd = i_wb_val;
`endif
      else
         rd = regs[r];
   endfunction

   // A writeback match only matters when no later-stage forward already supplies the value.
   function automatic logic wb_hit(input logic [3:0] r);
      wb_hit = (r != 4'd0) && (i_wb_reg == r) && (i_of_reg != r) && (i_mem_of_reg != r);
   endfunction

   assign vx = rd(rx);
   assign vy = rd(ry);
   assign vz = rd(rz);

   always_comb begin
      d_op      = op;
      d_dr      = 4'd0;
      d_skp     = 1'b0;
      d_sr1     = 32'd0;
      d_sr2     = 32'd0;
      d_tgt     = 32'd0;
      bubble_op = 1'b0;
      use_x     = 1'b0;
      use_y     = 1'b0;
      use_z     = 1'b0;
      case (op)
         4'd0, 4'd1: begin
            d_dr = rx; d_sr1 = vy; d_sr2 = vz; use_y = 1'b1; use_z = 1'b1;
         end
         4'd2: begin
            d_dr = rx; d_sr1 = vy; d_sr2 = imm; use_y = 1'b1;
         end
         4'd3: begin
            d_dr = rx; d_sr1 = vy; d_sr2 = imm; d_tgt = vy + imm; use_y = 1'b1;
         end
         4'd4: begin
            d_sr1 = vy; d_sr2 = vx; d_tgt = vy + imm; use_x = 1'b1; use_y = 1'b1;
         end
         4'd5: d_tgt = i_pc + 32'd1 + imm;
         4'd6: begin
            d_dr = ry; d_sr1 = vx; use_x = 1'b1;
         end
         4'd7: ;
         4'd8: begin
            d_sr1 = vx; d_sr2 = vy; d_skp = i_instr[0]; d_tgt = i_pc + 32'd2;
            use_x = 1'b1; use_y = 1'b1;
         end
         4'd9: begin
            d_dr = rx; d_tgt = i_pc + 32'd1 + imm;
         end
         default: begin
            d_op = 4'd0; bubble_op = 1'b1;
         end
      endcase
   end

   assign load_use = (o_opcode == 4'd3) && (o_dr != 4'd0) &&
                     ((use_x && o_dr == rx) || (use_y && o_dr == ry) || (use_z && o_dr == rz));
`ifdef TL45_WB_BYPASS_EN
   assign wb_haz = 1'b0;
`else
   assign wb_haz = (use_x && wb_hit(rx)) || (use_y && wb_hit(ry)) || (use_z && wb_hit(rz));
`endif
   assign hazard = i_valid && (load_use || wb_haz);

   assign o_pipe_stall = i_pipe_stall | o_halted | (hazard & ~i_pipe_flush);
   assign o_pipe_flush = i_pipe_flush;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < 16; i++) regs[i] <= 32'd0;
      end else if (i_wb_reg != 4'd0) begin
         regs[i_wb_reg] <= i_wb_val;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_halted <= 1'b0;
      end else if (o_opcode == 4'd7 && !i_pipe_flush) begin
         o_halted <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset || i_pipe_flush ||
          (!i_pipe_stall && (o_halted || hazard || !i_valid || bubble_op))) begin
         o_opcode         <= 4'd0;
         o_dr             <= 4'd0;
         o_skp_mode       <= 1'b0;
         o_pc             <= 32'd0;
         o_sr1_val        <= 32'd0;
         o_sr2_val        <= 32'd0;
         o_target_address <= 32'd0;
      end else if (!i_pipe_stall) begin
         o_opcode         <= d_op;
         o_dr             <= d_dr;
         o_skp_mode       <= d_skp;
         o_pc             <= i_pc;
         o_sr1_val        <= d_sr1;
         o_sr2_val        <= d_sr2;
         o_target_address <= d_tgt;
      end
   end

endmodule

// File: tb/tb_tl45_decode.sv
// tb/tb_tl45_decode.sv - scoreboard bench for tl45_decode using directed instruction vectors.
module tb_tl45_decode;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_stall_in, pipe_stall_out, pipe_flush_in, pipe_flush_out;
   logic        valid;
   logic [31:0] instr, pc;
   logic [3:0]  of_reg, mem_of_reg, wb_reg;
   logic [31:0] of_val, mem_of_val, wb_val;
   logic [3:0]  opcode, dr;
   logic        skp_mode, halted;
   logic [31:0] o_pc, sr1, sr2, tgt;

   typedef struct packed {
      logic [3:0]  op;
      logic [3:0]  dr;
      logic        skp;
      logic [31:0] pc;
      logic [31:0] sr1;
      logic [31:0] sr2;
      logic [31:0] tgt;
      logic        halted;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   tl45_decode dut (
      .i_clk(clk), .i_reset(rst),
      .i_pipe_stall(pipe_stall_in), .o_pipe_stall(pipe_stall_out),
      .i_pipe_flush(pipe_flush_in), .o_pipe_flush(pipe_flush_out),
      .i_valid(valid), .i_instr(instr), .i_pc(pc),
      .i_of_reg(of_reg), .i_of_val(of_val),
      .i_mem_of_reg(mem_of_reg), .i_mem_of_val(mem_of_val),
      .i_wb_reg(wb_reg), .i_wb_val(wb_val),
      .o_opcode(opcode), .o_dr(dr), .o_skp_mode(skp_mode), .o_pc(o_pc),
      .o_sr1_val(sr1), .o_sr2_val(sr2), .o_target_address(tgt),
      .o_halted(halted)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [3:0] op, input logic [3:0] d, input logic s,
                               input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] t, input logic h);
      exp_t e;
      e.op = op; e.dr = d; e.skp = s; e.pc = p; e.sr1 = a; e.sr2 = b; e.tgt = t; e.halted = h;
      return e;
   endfunction

   function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] x,
                                       input logic [3:0] y, input logic [19:0] low);
      return {op, x, y, low};
   endfunction

   // Monitor: the buffer is observed one cycle after the vector that produced it.
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("opcode", {28'd0, opcode}, {28'd0, e.op});
         chk("dr", {28'd0, dr}, {28'd0, e.dr});
         chk("skp_mode", {31'd0, skp_mode}, {31'd0, e.skp});
         chk("pc", o_pc, e.pc);
         chk("sr1", sr1, e.sr1);
         chk("sr2", sr2, e.sr2);
         chk("target", tgt, e.tgt);
         chk("halted", {31'd0, halted}, {31'd0, e.halted});
      end
   end

   task automatic cyc();
      @(negedge clk);
      rst = 1'b0; pipe_stall_in = 1'b0; pipe_flush_in = 1'b0; valid = 1'b0;
      instr = 32'd0; pc = 32'd0;
      of_reg = 4'd0; of_val = 32'd0; mem_of_reg = 4'd0; mem_of_val = 32'd0;
      wb_reg = 4'd0; wb_val = 32'd0;
   endtask

   task automatic issue(input exp_t e, input logic exp_stall, input string tag);
      #1;
      chk({tag, "_stall"}, {31'd0, pipe_stall_out}, {31'd0, exp_stall});
      chk({tag, "_flush"}, {31'd0, pipe_flush_out}, {31'd0, pipe_flush_in});
      sb.push_back(e);
      @(posedge clk);
   endtask

   exp_t z;

   initial begin
      z = mk(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(); rst = 1'b1; issue(z, 1'b0, "reset");
      cyc(); rst = 1'b1; issue(z, 1'b0, "reset2");

      cyc(); wb_reg = 3; wb_val = 32'h12345678; issue(z, 1'b0, "wb_r3");
      cyc(); valid = 1; pc = 32'h100; instr = enc(0, 1, 3, 20'h0);
      issue(mk(0, 1, 0, 32'h100, 32'h12345678, 0, 0, 0), 1'b0, "add");

      cyc(); valid = 1; pc = 32'h104; instr = enc(2, 2, 5, 20'hFFFFF);
      of_reg = 5; of_val = 7; mem_of_reg = 5; mem_of_val = 9;
      issue(mk(2, 2, 0, 32'h104, 7, 32'hFFFFFFFF, 0, 0), 1'b0, "addi_fwd");

      cyc(); valid = 1; pc = 32'h108; instr = enc(1, 7, 3, 20'h3);
      mem_of_reg = 3; mem_of_val = 32'hAA;
      issue(mk(1, 7, 0, 32'h108, 32'hAA, 32'hAA, 0, 0), 1'b0, "nand_mem");

      cyc(); valid = 1; pc = 32'h10C; instr = enc(3, 4, 1, 20'h0);
      of_reg = 1; of_val = 32'h40;
      issue(mk(3, 4, 0, 32'h10C, 32'h40, 0, 32'h40, 0), 1'b0, "lw");
      cyc(); valid = 1; pc = 32'h110; instr = enc(0, 6, 4, 20'h4);
      issue(z, 1'b1, "loaduse");
      cyc(); valid = 1; pc = 32'h110; instr = enc(0, 6, 4, 20'h4);
      mem_of_reg = 4; mem_of_val = 32'h55;
      issue(mk(0, 6, 0, 32'h110, 32'h55, 32'h55, 0, 0), 1'b0, "after_lu");

      cyc(); valid = 1; pc = 32'h10; instr = enc(5, 0, 0, 20'h5);
      issue(mk(5, 0, 0, 32'h10, 0, 0, 32'h16, 0), 1'b0, "goto");
      cyc(); valid = 1; pc = 32'h14; instr = enc(0, 1, 3, 20'h0);
      pipe_stall_in = 1; pipe_flush_in = 1;
      issue(z, 1'b1, "flush_stall");

      cyc(); valid = 1; pc = 32'h20; instr = enc(9, 9, 0, 20'hFFFFE);
      issue(mk(9, 9, 0, 32'h20, 0, 0, 32'h1F, 0), 1'b0, "lea");
      cyc(); valid = 1; pc = 32'h24; instr = enc(0, 1, 3, 20'h0); pipe_stall_in = 1;
      issue(mk(9, 9, 0, 32'h20, 0, 0, 32'h1F, 0), 1'b1, "hold");

      cyc(); valid = 1; pc = 32'h30; instr = enc(4, 3, 0, 20'h8);
      issue(mk(4, 0, 0, 32'h30, 0, 32'h12345678, 32'h8, 0), 1'b0, "sw");
      cyc(); valid = 1; pc = 32'h40; instr = enc(8, 3, 1, 20'h1);
      issue(mk(8, 0, 1, 32'h40, 32'h12345678, 0, 32'h42, 0), 1'b0, "skp");
      cyc(); valid = 1; pc = 32'h44; instr = enc(6, 3, 14, 20'h0);
      issue(mk(6, 14, 0, 32'h44, 32'h12345678, 0, 0, 0), 1'b0, "jalr");

      cyc(); valid = 1; pc = 32'h50; instr = enc(3, 5, 0, 20'h0);
      issue(mk(3, 5, 0, 32'h50, 0, 0, 0, 0), 1'b0, "lw2");
      cyc(); valid = 1; pc = 32'h54; instr = enc(2, 1, 5, 20'h1); pipe_flush_in = 1;
      issue(z, 1'b0, "flush_hazard");

      cyc(); valid = 1; pc = 32'h60; instr = enc(0, 8, 3, 20'h0);
      wb_reg = 3; wb_val = 32'h99;
`ifdef TL45_WB_BYPASS_EN
      issue(mk(0, 8, 0, 32'h60, 32'h99, 0, 0, 0), 1'b0, "wb_same");
`else
      issue(z, 1'b1, "wb_same");
`endif
      cyc(); valid = 1; pc = 32'h60; instr = enc(0, 8, 3, 20'h0);
      issue(mk(0, 8, 0, 32'h60, 32'h99, 0, 0, 0), 1'b0, "wb_after");

      cyc(); valid = 1; pc = 32'h64; instr = enc(12, 1, 3, 20'h3);
      issue(z, 1'b0, "illegal_op");

      cyc(); valid = 1; pc = 32'h70; instr = enc(7, 0, 0, 20'h0);
      issue(mk(7, 0, 0, 32'h70, 0, 0, 0, 0), 1'b0, "halt");
      cyc(); issue(mk(0, 0, 0, 0, 0, 0, 0, 1), 1'b0, "halt_set");
      cyc(); valid = 1; pc = 32'h74; instr = enc(0, 1, 3, 20'h0);
      issue(mk(0, 0, 0, 0, 0, 0, 0, 1), 1'b1, "halted");
      cyc(); rst = 1'b1; valid = 1; pc = 32'h78; instr = enc(0, 1, 3, 20'h0);
      issue(z, 1'b1, "reset_halt");
      cyc(); valid = 1; pc = 32'h80; instr = enc(0, 1, 3, 20'h0);
      issue(mk(0, 1, 0, 32'h80, 0, 0, 0, 0), 1'b0, "regs_cleared");

      cyc(); cyc();
      chk("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
